// File: rtl/hub75_capture.sv
// HUB75 receive-side capture: oversamples the panel pins, rebuilds each latched row pair
// into a ready/valid pixel stream. Define HUB75_CAPTURE_ERR_EN to include the sticky error flags.
module hub75_capture #(
  parameter int NUM_ROWS    = 32,
  parameter int NUM_COLS    = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_in,
  input  logic                        n_reset_in,
  input  logic                        bit_clk_in,
  input  logic                        latch_in,
  input  logic                        output_enable_in,
  input  logic [$clog2(NUM_ROWS)-2:0] addr_in,
  input  logic [2:0]                  rgb_top_in,
  input  logic [2:0]                  rgb_bot_in,
  output logic                        px_valid_out,
  input  logic                        px_ready_in,
  output logic [$clog2(NUM_ROWS)-1:0] px_row_out,
  output logic [$clog2(NUM_COLS)-1:0] px_col_out,
  output logic [2:0]                  px_rgb_out,
  output logic                        frame_done_out,
  input  logic                        clear_err_in,
  output logic                        col_err_out,
  output logic                        overrun_err_out,
  output logic                        blank_err_out
);

  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int ADDR_W = ROW_W - 1;
  localparam int BEATS  = 2 * NUM_COLS;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int CNT_W  = $clog2(NUM_COLS + 2);
  localparam int SYNC_W = 3 + ADDR_W + 6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } state_t;

  logic [SYNC_W-1:0] pins_s;
  logic [SYNC_W-1:0] sync_r [SYNC_STAGES];
  logic              bclk_s;
  logic              latch_s;
  logic              oe_s;
  logic [ADDR_W-1:0] addr_s;
  logic [2:0]        top_s;
  logic [2:0]        bot_s;

  logic              bclk_q_r;
  logic              latch_q_r;
  logic              bit_rise_r;
  logic              latch_rise_r;
  logic              oe_d_r;
  logic [ADDR_W-1:0] addr_d_r;
  logic [2:0]        top_d_r;
  logic [2:0]        bot_d_r;

  logic [2:0]        shift_top_r [NUM_COLS];
  logic [2:0]        shift_bot_r [NUM_COLS];
  logic [2:0]        hold_top_r  [NUM_COLS];
  logic [2:0]        hold_bot_r  [NUM_COLS];
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [ADDR_W-1:0] row_base_r;
  logic [BEAT_W-1:0] beat_r;

  state_t            state_r;
  state_t            state_nx_s;
  logic              capture_s;
  logic              issue_s;
  logic              accept_s;
  logic              done_s;
  logic [COL_W-1:0]  issue_col_s;
  logic              issue_half_s;
  logic [2:0]        issue_rgb_s;

  logic              px_valid_r;
  logic [ROW_W-1:0]  px_row_r;
  logic [COL_W-1:0]  px_col_r;
  logic [2:0]        px_rgb_r;
  logic              px_last_frame_r;
  logic              frame_done_r;

  assign pins_s = {bit_clk_in, latch_in, output_enable_in, addr_in, rgb_top_in, rgb_bot_in};
  assign {bclk_s, latch_s, oe_s, addr_s, top_s, bot_s} = sync_r[SYNC_STAGES-1];

  // Synchronize every panel pin through an equal-depth chain so clock and data stay aligned
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= pins_s;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Edge detect stage; data, OE and address are delayed alongside so events see aligned values
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      bclk_q_r     <= 1'b0;
      latch_q_r    <= 1'b0;
      bit_rise_r   <= 1'b0;
      latch_rise_r <= 1'b0;
      oe_d_r       <= 1'b0;
      addr_d_r     <= '0;
      top_d_r      <= 3'b000;
      bot_d_r      <= 3'b000;
    end else begin
      bclk_q_r     <= bclk_s;
      latch_q_r    <= latch_s;
      bit_rise_r   <= bclk_s & ~bclk_q_r;
      latch_rise_r <= latch_s & ~latch_q_r;
      oe_d_r       <= oe_s;
      addr_d_r     <= addr_s;
      top_d_r      <= top_s;
      bot_d_r      <= bot_s;
    end
  end

  // Column shift registers: new bit enters at the far end, so the first bit lands at column 0
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        shift_top_r[i] <= 3'b000;
        shift_bot_r[i] <= 3'b000;
      end
    end else if (bit_rise_r) begin
      for (int i = 0; i < NUM_COLS - 1; i++) begin
        shift_top_r[i] <= shift_top_r[i+1];
        shift_bot_r[i] <= shift_bot_r[i+1];
      end
      shift_top_r[NUM_COLS-1] <= top_d_r;
      shift_bot_r[NUM_COLS-1] <= bot_d_r;
    end
  end

  // Bit counter: cleared by any latch, saturates one past the expected width
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      bit_cnt_r <= '0;
    end else if (latch_rise_r) begin
      bit_cnt_r <= bit_rise_r ? CNT_W'(1) : CNT_W'(0);
    end else if (bit_rise_r && (bit_cnt_r != CNT_W'(NUM_COLS + 1))) begin
      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
    end
  end

  assign capture_s = latch_rise_r && (state_r == ST_IDLE);
  assign accept_s  = px_valid_r && px_ready_in;
  assign issue_s   = (state_r == ST_DUMP) && (beat_r != BEAT_W'(BEATS)) && (!px_valid_r || px_ready_in);
  assign done_s    = (state_r == ST_DUMP) && (beat_r == BEAT_W'(BEATS)) && accept_s;

  // FSM state register
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: DUMP lasts until the final beat has left the output register
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) state_nx_s = ST_DUMP;
        else           state_nx_s = ST_IDLE;
      end
      ST_DUMP: begin
        if (done_s) state_nx_s = ST_IDLE;
        else        state_nx_s = ST_DUMP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Beat payload selection: first half of the beats is the top buffer, second half the bottom
  always_comb begin
    issue_col_s  = beat_r[COL_W-1:0];
    issue_half_s = beat_r[COL_W];
    if (issue_half_s) issue_rgb_s = hold_bot_r[issue_col_s];
    else              issue_rgb_s = hold_top_r[issue_col_s];
  end

  // Holding buffer and row base are written only when a latch is accepted from IDLE
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        hold_top_r[i] <= 3'b000;
        hold_bot_r[i] <= 3'b000;
      end
      row_base_r <= '0;
    end else if (capture_s) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        hold_top_r[i] <= shift_top_r[i];
        hold_bot_r[i] <= shift_bot_r[i];
      end
      row_base_r <= addr_d_r;
    end
  end

  // Beat index advances each time a beat moves into the output register
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      beat_r <= '0;
    end else if (capture_s) begin
      beat_r <= '0;
    end else if (issue_s) begin
      beat_r <= beat_r + BEAT_W'(1);
    end
  end

  // Registered output beat; payload holds while stalled
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      px_valid_r      <= 1'b0;
      px_row_r        <= '0;
      px_col_r        <= '0;
      px_rgb_r        <= 3'b000;
      px_last_frame_r <= 1'b0;
      frame_done_r    <= 1'b0;
    end else begin
      frame_done_r <= accept_s && px_last_frame_r;
      if (issue_s) begin
        px_valid_r      <= 1'b1;
        px_row_r        <= {issue_half_s, row_base_r};
        px_col_r        <= issue_col_s;
        px_rgb_r        <= issue_rgb_s;
        px_last_frame_r <= (beat_r == BEAT_W'(BEATS - 1)) &&
                           (row_base_r == ADDR_W'(NUM_ROWS / 2 - 1));
      end else if (accept_s) begin
        px_valid_r      <= 1'b0;
        px_last_frame_r <= 1'b0;
      end
    end
  end

  assign px_valid_out   = px_valid_r;
  assign px_row_out     = px_row_r;
  assign px_col_out     = px_col_r;
  assign px_rgb_out     = px_rgb_r;
  assign frame_done_out = frame_done_r;

`ifdef HUB75_CAPTURE_ERR_EN
  logic overrun_s;
  logic col_err_r;
  logic overrun_err_r;
  logic blank_err_r;

  assign overrun_s = latch_rise_r && (state_r == ST_DUMP);

  // Sticky error flags; a set in the same cycle as a clear takes priority
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      col_err_r     <= 1'b0;
      overrun_err_r <= 1'b0;
      blank_err_r   <= 1'b0;
    end else begin
      if (capture_s && (bit_cnt_r != CNT_W'(NUM_COLS))) col_err_r <= 1'b1;
      else if (clear_err_in)                             col_err_r <= 1'b0;

      if (overrun_s)         overrun_err_r <= 1'b1;
      else if (clear_err_in) overrun_err_r <= 1'b0;

      if (capture_s && !oe_d_r) blank_err_r <= 1'b1;
      else if (clear_err_in)    blank_err_r <= 1'b0;
    end
  end

  assign col_err_out     = col_err_r;
  assign overrun_err_out = overrun_err_r;
  assign blank_err_out   = blank_err_r;
`else
  logic unused_err_s;

  assign unused_err_s    = clear_err_in ^ oe_d_r;
  assign col_err_out     = 1'b0;
  assign overrun_err_out = 1'b0;
  assign blank_err_out   = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Randomized scoreboard bench for hub75_capture: a history-of-shifted-bits model predicts each
// latched row pair; a monitor on the falling clock edge pops and compares accepted beats.
`timescale 1ns/1ps
module tb_hub75_capture;

  localparam int NUM_ROWS    = 32;
  localparam int NUM_COLS    = 64;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = NUM_ROWS / 2;
`ifdef HUB75_CAPTURE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_reset_in;
  logic       bit_clk_in, latch_in, output_enable_in;
  logic [3:0] addr_in;
  logic [2:0] rgb_top_in, rgb_bot_in;
  logic       px_valid_out, px_ready_in;
  logic [4:0] px_row_out;
  logic [5:0] px_col_out;
  logic [2:0] px_rgb_out;
  logic       frame_done_out, clear_err_in;
  logic       col_err_out, overrun_err_out, blank_err_out;

  hub75_capture #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_in(clk), .n_reset_in(n_reset_in), .bit_clk_in(bit_clk_in), .latch_in(latch_in),
    .output_enable_in(output_enable_in), .addr_in(addr_in), .rgb_top_in(rgb_top_in),
    .rgb_bot_in(rgb_bot_in), .px_valid_out(px_valid_out), .px_ready_in(px_ready_in),
    .px_row_out(px_row_out), .px_col_out(px_col_out), .px_rgb_out(px_rgb_out),
    .frame_done_out(frame_done_out), .clear_err_in(clear_err_in), .col_err_out(col_err_out),
    .overrun_err_out(overrun_err_out), .blank_err_out(blank_err_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] row;
    logic [5:0] col;
    logic [2:0] rgb;
    logic       fd;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  logic [2:0] hist_top[$];
  logic [2:0] hist_bot[$];
  int         bits_since_latch = 0;
  bit         busy = 1'b0;
  bit         exp_col = 1'b0, exp_ovr = 1'b0, exp_blank = 1'b0;
  bit         rand_ready = 1'b0;
  int         checks = 0, errors = 0;
  int         acc_cnt = 0, fd_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic [2:0] t, input logic [2:0] b);
    bit_clk_in = 1'b0;
    rgb_top_in = t;
    rgb_bot_in = b;
    tick(3);
    bit_clk_in = 1'b1;
    hist_top.push_back(t);
    hist_bot.push_back(b);
    bits_since_latch++;
    tick(3);
    bit_clk_in = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_col_err"}, int'(col_err_out), int'(ERR_EN && exp_col));
    chk({tag, "_overrun_err"}, int'(overrun_err_out), int'(ERR_EN && exp_ovr));
    chk({tag, "_blank_err"}, int'(blank_err_out), int'(ERR_EN && exp_blank));
  endtask

  // Latch the current shift contents; the model predicts the beats from the last NUM_COLS shifted bits
  task automatic do_latch(input logic [3:0] addr, input bit measure);
    int         idx, lat;
    logic [2:0] v;
    beat_t      e;
    addr_in = addr;
    tick(3);
    if (busy) begin
      exp_ovr = 1'b1;
    end else begin
      if (bits_since_latch != NUM_COLS) exp_col = 1'b1;
      if (!output_enable_in) exp_blank = 1'b1;
      for (int h = 0; h < 2; h++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          idx = int'(hist_top.size()) - NUM_COLS + c;
          if (idx >= 0) v = (h == 1) ? hist_bot[idx] : hist_top[idx];
          else          v = 3'b000;
          e.row  = 5'(h * HALF + int'(addr));
          e.col  = 6'(c);
          e.rgb  = v;
          e.last = (h == 1) && (c == NUM_COLS - 1);
          e.fd   = e.last && (int'(addr) == HALF - 1);
          exp_q.push_back(e);
        end
      end
      busy = 1'b1;
    end
    bits_since_latch = 0;
    latch_in = 1'b1;
    if (measure) begin
      lat = 0;
      @(posedge clk);
      while (lat < 20) begin
        @(negedge clk);
        if (px_valid_out === 1'b1) break;
        @(posedge clk);
        lat++;
      end
      chk("valid_latency", lat, SYNC_STAGES + 2);
      tick(1);
    end else begin
      tick(4);
    end
    latch_in = 1'b0;
    tick(3);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_within_budget", int'(n < 4000), 1);
  endtask

  // mode 0: top = column mod 8, bottom = its inverse; mode 1: random colours
  task automatic send_row(input logic [3:0] addr, input int nbits, input int mode, input bit measure);
    logic [2:0] t;
    int n = 0;
    for (int i = 0; i < nbits; i++) begin
      if (mode == 0) t = 3'(i % 8);
      else           t = 3'($urandom_range(0, 7));
      shift_bit(t, (mode == 0) ? ~t : 3'($urandom_range(0, 7)));
    end
    while (busy && n < 4000) begin
      tick(1);
      n++;
    end
    do_latch(addr, measure);
  endtask

  task automatic pulse_clear();
    clear_err_in = 1'b1;
    tick(1);
    clear_err_in = 1'b0;
    exp_col   = 1'b0;
    exp_ovr   = 1'b0;
    exp_blank = 1'b0;
  endtask

  // Sink ready: held high, or randomly toggled when rand_ready is set
  initial begin
    px_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      px_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare accepted beats against the scoreboard, stall stability and frame_done timing
  initial begin
    bit         prev_stall = 1'b0;
    bit         fd_exp = 1'b0;
    logic [13:0] saved = '0;
    beat_t      e;
    forever begin
      @(negedge clk);
      if (n_reset_in !== 1'b1) begin
        prev_stall = 1'b0;
        fd_exp = 1'b0;
        continue;
      end
      chk("frame_done", int'(frame_done_out), int'(fd_exp));
      if (frame_done_out) fd_cnt++;
      fd_exp = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", int'(px_valid_out), 1);
        chk("stall_payload", int'({px_row_out, px_col_out, px_rgb_out}), int'(saved));
      end
      if (px_valid_out && px_ready_in) begin
        acc_cnt++;
        chk("beat_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("px_row", int'(px_row_out), int'(e.row));
          chk("px_col", int'(px_col_out), int'(e.col));
          chk("px_rgb", int'(px_rgb_out), int'(e.rgb));
          if (e.fd) fd_exp = 1'b1;
          if (e.last) busy = 1'b0;
        end
      end
      prev_stall = px_valid_out && !px_ready_in;
      saved = {px_row_out, px_col_out, px_rgb_out};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, fd0;
    n_reset_in = 1'b0;
    bit_clk_in = 1'b0;
    latch_in = 1'b0;
    output_enable_in = 1'b1;
    addr_in = 4'd0;
    rgb_top_in = 3'b000;
    rgb_bot_in = 3'b000;
    clear_err_in = 1'b0;
    tick(3);
    chk("reset_valid", int'(px_valid_out), 0);
    chk("reset_payload", int'({px_row_out, px_col_out, px_rgb_out}), 0);
    chk("reset_frame_done", int'(frame_done_out), 0);
    check_flags("reset");
    n_reset_in = 1'b1;
    tick(3);

    // Pattern row at address 3 with latency measurement
    send_row(4'd3, NUM_COLS, 0, 1'b1);
    wait_idle();
    check_flags("pattern_row");

    // Short row: col_err sticky until cleared
    send_row(4'($urandom_range(0, 15)), NUM_COLS - 1, 1, 1'b0);
    wait_idle();
    check_flags("short_row");
    tick(10);
    check_flags("short_row_sticky");
    pulse_clear();
    check_flags("short_row_cleared");

    // Overrun: second latch about 20 cycles into the drain
    send_row(4'($urandom_range(0, 15)), NUM_COLS, 1, 1'b0);
    tick(14);
    do_latch(4'($urandom_range(0, 15)), 1'b0);
    wait_idle();
    tick(20);
    check_flags("overrun");
    chk("overrun_no_extra_row", int'(px_valid_out), 0);
    pulse_clear();
    check_flags("overrun_cleared");

    // Random backpressure
    acc0 = acc_cnt;
    rand_ready = 1'b1;
    send_row(4'($urandom_range(0, 15)), NUM_COLS, 1, 1'b0);
    wait_idle();
    rand_ready = 1'b0;
    chk("stalled_beat_count", acc_cnt - acc0, 2 * NUM_COLS);

    // Full frame scan
    fd0 = fd_cnt;
    for (int a = 0; a < HALF; a++) send_row(4'(a), NUM_COLS, 1, 1'b0);
    wait_idle();
    tick(5);
    chk("frame_done_pulses", fd_cnt - fd0, 1);
    check_flags("frame_scan");

    // Latch while OE low
    output_enable_in = 1'b0;
    send_row(4'($urandom_range(0, 15)), NUM_COLS, 1, 1'b0);
    output_enable_in = 1'b1;
    wait_idle();
    check_flags("blank");
    pulse_clear();
    check_flags("blank_cleared");

    // Reset in the middle of a drain
    send_row(4'd5, NUM_COLS, 1, 1'b0);
    tick(30);
    n_reset_in = 1'b0;
    #1;
    chk("midreset_valid", int'(px_valid_out), 0);
    chk("midreset_payload", int'({px_row_out, px_col_out, px_rgb_out}), 0);
    chk("midreset_frame_done", int'(frame_done_out), 0);
    exp_q.delete();
    hist_top.delete();
    hist_bot.delete();
    bits_since_latch = 0;
    busy = 1'b0;
    exp_col = 1'b0;
    exp_ovr = 1'b0;
    exp_blank = 1'b0;
    check_flags("midreset");
    tick(4);
    n_reset_in = 1'b1;
    tick(100);
    chk("post_reset_idle", int'(px_valid_out), 0);

    // A fresh row after reset drains normally
    send_row(4'd15, NUM_COLS, 1, 1'b0);
    wait_idle();
    tick(5);
    check_flags("post_reset_row");
    chk("scoreboard_empty", int'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
